// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM master that reads the sysid words and checks them against build-time values.
// Define SYSID_CHECK_TIMEOUT_EN to add a per-read waitrequest timeout and ERR state.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1396677201,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        error
);

`ifdef SYSID_CHECK_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_DONE  = 3'd3
  } state_t;
`endif

  state_t state, state_nx;
  logic   pending, pending_nx;
  logic   cap_id, cap_ts;
  logic   rd_nx, done_nx;
  logic   to_hit;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt;

  assign to_hit = avm_waitrequest && (cnt == TO_LIM);

  // Counter restarts whenever the state changes, so each read gets its own budget.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      if (state_nx != state)
        cnt <= '0;
      else if (avm_read && avm_waitrequest)
        cnt <= cnt + 16'd1;
      error <= (state_nx == S_ERR);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
  assign error  = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    cap_id     = 1'b0;
    cap_ts     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pending || start) begin
          pending_nx = 1'b0;
          state_nx   = S_RD_ID;
        end
      end
      S_RD_ID: begin
        if (!avm_waitrequest) begin
          cap_id   = 1'b1;
          state_nx = S_RD_TS;
        end
`ifdef SYSID_CHECK_TIMEOUT_EN
        else if (to_hit) begin
          state_nx = S_ERR;
        end
`endif
      end
      S_RD_TS: begin
        if (!avm_waitrequest) begin
          cap_ts   = 1'b1;
          state_nx = S_DONE;
        end
`ifdef SYSID_CHECK_TIMEOUT_EN
        else if (to_hit) begin
          state_nx = S_ERR;
        end
`endif
      end
      S_DONE: begin
        if (start) state_nx = S_RD_ID;
      end
`ifdef SYSID_CHECK_TIMEOUT_EN
      S_ERR: begin
        if (start) state_nx = S_RD_ID;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_nx   = (state_nx == S_RD_ID) || (state_nx == S_RD_TS);
`ifdef SYSID_CHECK_TIMEOUT_EN
    done_nx = (state_nx == S_DONE) || (state_nx == S_ERR);
`else
    done_nx = (state_nx == S_DONE);
`endif
  end

  // Outputs are registered from next-state so Avalon inputs never reach them directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      pending         <= 1'b1;
      avm_read        <= 1'b0;
      avm_address     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      match           <= 1'b0;
      id_value        <= '0;
      timestamp_value <= '0;
    end else begin
      state       <= state_nx;
      pending     <= pending_nx;
      avm_read    <= rd_nx;
      avm_address <= (state_nx == S_RD_TS);
      busy        <= rd_nx;
      done        <= done_nx;
      if (cap_id)
        id_value <= avm_readdata;
      if (cap_ts) begin
        timestamp_value <= avm_readdata;
        match <= (id_value == EXPECTED_ID) &&
                 (avm_readdata == EXPECTED_TIMESTAMP);
      end else if (state_nx == S_RD_ID) begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for niosii_system_sysid_checker with a small Avalon slave model.
// Build with SYSID_CHECK_TIMEOUT_EN defined to exercise the timeout path.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'd1396677201;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;
  logic        busy;
  logic        done;
  logic        match;
  logic        error;

  niosii_system_sysid_checker #(
    .EXPECTED_ID        (32'd0),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (8)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .id_value        (id_value),
    .timestamp_value (timestamp_value),
    .busy            (busy),
    .done            (done),
    .match           (match),
    .error           (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] sid;
  logic [31:0] sts;
  int          wait_n;
  logic        stuck;
  int          wcnt;

  // Slave model: stall wait_n cycles per read, or forever when stuck.
  initial begin
    avm_waitrequest = 1'b0;
    avm_readdata    = '0;
    wcnt            = 0;
    forever begin
      @(negedge clock);
      avm_readdata = avm_address ? sts : sid;
      if (!avm_read) begin
        avm_waitrequest = 1'b0;
        wcnt = 0;
      end else if (stuck) begin
        avm_waitrequest = 1'b1;
      end else if (wcnt < wait_n) begin
        avm_waitrequest = 1'b1;
        wcnt++;
      end else begin
        avm_waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_outputs",
        {28'd0, avm_read, busy, done, match | error},
        32'd0);
    chk("rst_id", id_value, 32'd0);
    chk("rst_ts", timestamp_value, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    int          wn;
    logic        exp_match;
    int          exp_edge;
  } vec_t;

  vec_t vecs[5];

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    sid     = '0;
    sts     = EXP_TS;
    wait_n  = 0;
    stuck   = 1'b0;

    vecs[0] = '{32'd0,          EXP_TS,         0, 1'b1, 3};
    vecs[1] = '{32'd1,          EXP_TS,         0, 1'b0, 3};
    vecs[2] = '{32'd0,          EXP_TS,         4, 1'b1, 11};
    vecs[3] = '{32'd0,          32'hDEAD_BEEF,  1, 1'b0, 5};
    vecs[4] = '{32'hFFFF_FFFF,  32'd0,          2, 1'b0, 7};

    #2;
    for (int v = 0; v < 5; v++) begin
      int   got;
      int   rdc;
      int   bad;
      logic pre_wr, pre_rd, pre_addr;
      sid    = vecs[v].id;
      sts    = vecs[v].ts;
      wait_n = vecs[v].wn;
      got = 0;
      rdc = 0;
      bad = 0;
      do_reset();
      #1;
      pre_wr = avm_waitrequest; pre_rd = avm_read; pre_addr = avm_address;
      for (int e = 1; e <= 60; e++) begin
        tick();
        if (avm_read) rdc++;
        if (pre_rd && pre_wr && (!avm_read || avm_address != pre_addr))
          bad++;
        if (done) begin
          got = e;
          break;
        end
        @(negedge clock);
        #1;
        pre_wr = avm_waitrequest; pre_rd = avm_read; pre_addr = avm_address;
      end
      chk($sformatf("v%0d_done_edge", v), got, vecs[v].exp_edge);
      chk($sformatf("v%0d_match", v), {31'd0, match}, {31'd0, vecs[v].exp_match});
      chk($sformatf("v%0d_id", v), id_value, vecs[v].id);
      chk($sformatf("v%0d_ts", v), timestamp_value, vecs[v].ts);
      chk($sformatf("v%0d_error", v), {31'd0, error}, 32'd0);
      chk($sformatf("v%0d_idle", v), {30'd0, avm_read, busy}, 32'd0);
      chk($sformatf("v%0d_read_cycles", v), rdc, vecs[v].exp_edge - 1);
      chk($sformatf("v%0d_stall_stable", v), bad, 0);
    end

    // start during RD_TS is dropped; start in DONE re-reads
    sid = 32'd0; sts = EXP_TS; wait_n = 0;
    do_reset();
    tick();
    tick();
    chk("seqA_in_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
    @(negedge clock);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seqA_done_e3", {30'd0, done, match}, 32'd3);
    tick();
    tick();
    chk("seqA_not_queued", {30'd0, done, avm_read}, 32'd2);
    sid = 32'd5;
    @(negedge clock);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seqA_restart", {27'd0, done, avm_read, busy, match, avm_address},
        32'b01100);
    tick();
    chk("seqA_rd_ts", {30'd0, done, avm_address}, 32'd1);
    tick();
    chk("seqA_redone", {30'd0, done, match}, 32'd2);
    chk("seqA_new_id", id_value, 32'd5);

    // stalled slave: timeout or indefinite wait
    sid = 32'd0; sts = EXP_TS; stuck = 1'b1;
    do_reset();
`ifdef SYSID_CHECK_TIMEOUT_EN
    repeat (8) tick();
    chk("to_edge8", {29'd0, done, avm_read, error}, 32'b010);
    tick();
    chk("to_err", {27'd0, error, done, avm_read, match, busy}, 32'b11000);
    stuck = 1'b0;
    @(negedge clock);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_restart", {29'd0, error, done, avm_read}, 32'b001);
    tick();
    tick();
    chk("to_recover", {29'd0, done, match, error}, 32'b110);
`else
    repeat (1000) tick();
    chk("stall_1000", {28'd0, avm_read, busy, done, error}, 32'b1100);
    stuck = 1'b0;
`endif

    // reset mid-RD_TS then full rerun
    sid = 32'd7; sts = EXP_TS; stuck = 1'b0; wait_n = 0;
    do_reset();
    tick();
    tick();
    chk("rstmid_pre", {30'd0, avm_read, avm_address}, 32'd3);
    chk("rstmid_id", id_value, 32'd7);
    do_reset();
    tick();
    tick();
    chk("rstmid_e2", {30'd0, done, avm_read}, 32'd1);
    tick();
    chk("rstmid_e3", {30'd0, done, match}, 32'd2);
    chk("rstmid_id2", id_value, 32'd7);
    chk("rstmid_ts2", timestamp_value, EXP_TS);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
